// File: rtl/reveal_engine.sv
// Minesweeper reveal engine: queries the board one cell at a time. Zero-count regions
// are flood-filled through a FIFO of pending cells. The engine keeps the revealed bitmap.
module reveal_engine #(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               clear,
    input  logic [X_COORD_BITS-1:0]            sel_x,
    input  logic [Y_COORD_BITS-1:0]            sel_y,
    input  logic                               is_init,
    input  logic [4:0]                         cell_val,
    output logic [X_COORD_BITS-1:0]            x_coord,
    output logic [Y_COORD_BITS-1:0]            y_coord,
    input  logic [X_COORD_BITS-1:0]            rev_x,
    input  logic [Y_COORD_BITS-1:0]            rev_y,
    output logic                               rev_bit,
    output logic                               busy,
    output logic                               done,
    output logic                               hit_mine,
    output logic [X_COORD_BITS+Y_COORD_BITS:0] revealed_count,
    output logic [2:0]                         dbg_state
);

    localparam int XB    = X_COORD_BITS;
    localparam int YB    = Y_COORD_BITS;
    localparam int CELLS = X_SIZE * Y_SIZE;
    localparam int IW    = XB + YB;
    localparam int QW    = $clog2(CELLS);
    localparam int CW    = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_NBR   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [XB-1:0]      x_q;
    logic [YB-1:0]      y_q;
    logic [CELLS-1:0]   revealed_q;
    logic [CW-1:0]      count_q;
    logic               hit_q;
    logic               done_q;
    logic [QW-1:0]      head_q;
    logic [QW-1:0]      tail_q;
    logic [QW:0]        qcnt_q;
    logic [2:0]         nbr_q;
    logic [IW-1:0]      q_mem [CELLS];

    function automatic logic [IW-1:0] lin(input logic [XB-1:0] x, input logic [YB-1:0] y);
        return IW'(y) * IW'(X_SIZE) + IW'(x);
    endfunction

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(CELLS - 1)) ? '0 : p + QW'(1);
    endfunction

    // start is a one-cycle request with no ready: it is taken only in IDLE with the
    // board initialised and no mine hit; otherwise it is dropped and produces no done.
    logic start_ok;
    logic sel_seen;
    assign start_ok = start && (state_q == S_IDLE) && is_init && !hit_q;
    assign sel_seen = revealed_q[lin(sel_x, sel_y)];

    logic          xm, xp, ym, yp;
    logic          nbr_ok;
    logic [XB-1:0] nbr_x;
    logic [YB-1:0] nbr_y;

    // Neighbour order NW,N,NE,W,E,SW,S,SE; edges are clipped, never wrapped.
    always_comb begin
        xm = 1'b0; xp = 1'b0; ym = 1'b0; yp = 1'b0;
        case (nbr_q)
            3'd0:    begin xm = 1'b1; ym = 1'b1; end
            3'd1:    ym = 1'b1;
            3'd2:    begin xp = 1'b1; ym = 1'b1; end
            3'd3:    xm = 1'b1;
            3'd4:    xp = 1'b1;
            3'd5:    begin xm = 1'b1; yp = 1'b1; end
            3'd6:    yp = 1'b1;
            default: begin xp = 1'b1; yp = 1'b1; end
        endcase
        nbr_ok = !(xm && x_q == '0) && !(xp && x_q == XB'(X_SIZE - 1)) &&
                 !(ym && y_q == '0) && !(yp && y_q == YB'(Y_SIZE - 1));
        nbr_x  = xm ? x_q - XB'(1) : (xp ? x_q + XB'(1) : x_q);
        nbr_y  = ym ? y_q - YB'(1) : (yp ? y_q + YB'(1) : y_q);
    end

    logic          enq_en;
    logic [XB-1:0] enq_x;
    logic [YB-1:0] enq_y;
    logic [IW-1:0] enq_lin;

    always_comb begin
        enq_en = 1'b0;
        enq_x  = sel_x;
        enq_y  = sel_y;
        if (state_q == S_IDLE) begin
            enq_en = start_ok && !sel_seen;
        end else if (state_q == S_NBR) begin
            enq_x  = nbr_x;
            enq_y  = nbr_y;
            enq_en = nbr_ok && !revealed_q[lin(nbr_x, nbr_y)];
        end
        enq_lin = lin(enq_x, enq_y);
    end

    always_ff @(posedge clk) begin
        if (enq_en) q_mem[tail_q] <= {enq_y, enq_x};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            revealed_q <= '0;
            count_q    <= '0;
            hit_q      <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            qcnt_q     <= '0;
            nbr_q      <= '0;
        end else if (clear) begin
            state_q    <= S_IDLE;
            revealed_q <= '0;
            count_q    <= '0;
            hit_q      <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            qcnt_q     <= '0;
            nbr_q      <= '0;
        end else begin
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        if (enq_en) begin
                            revealed_q[enq_lin] <= 1'b1;
                            count_q             <= count_q + CW'(1);
                            tail_q              <= ptr_inc(tail_q);
                            qcnt_q              <= qcnt_q + (QW+1)'(1);
                            state_q             <= S_FETCH;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    {y_q, x_q} <= q_mem[head_q];
                    head_q     <= ptr_inc(head_q);
                    qcnt_q     <= qcnt_q - (QW+1)'(1);
                    state_q    <= S_EVAL;
                end
                S_EVAL: begin
                    if (cell_val[4]) begin
                        hit_q   <= 1'b1;
                        head_q  <= tail_q;
                        qcnt_q  <= '0;
                        state_q <= S_DONE;
                    end else if (cell_val[3:0] != 4'd0) begin
                        state_q <= (qcnt_q == '0) ? S_DONE : S_FETCH;
                    end else begin
                        nbr_q   <= '0;
                        state_q <= S_NBR;
                    end
                end
                S_NBR: begin
                    if (enq_en) begin
                        revealed_q[enq_lin] <= 1'b1;
                        count_q             <= count_q + CW'(1);
                        tail_q              <= ptr_inc(tail_q);
                        qcnt_q              <= qcnt_q + (QW+1)'(1);
                    end
                    nbr_q <= nbr_q + 3'd1;
                    if (nbr_q == 3'd7) begin
                        state_q <= (qcnt_q == '0 && !enq_en) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x_coord        = x_q;
    assign y_coord        = y_q;
    assign rev_bit        = revealed_q[lin(rev_x, rev_y)];
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign hit_mine       = hit_q;
    assign revealed_count = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_reveal_engine.sv
// Bench for reveal_engine: behavioural board, vector table of reveals, and
// hand-written sequences for reset, clear and flood-fill corners.
module tb_reveal_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear;
    logic [3:0] sel_x, sel_y;
    logic       is_init;
    logic [4:0] cell_val;
    logic [3:0] x_coord, y_coord;
    logic [3:0] rev_x, rev_y;
    logic       rev_bit;
    logic       busy;
    logic       done;
    logic       hit_mine;
    logic [8:0] revealed_count;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int layout   = 0;
    logic [8:0] exp_q[$];

    reveal_engine dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .sel_x(sel_x), .sel_y(sel_y), .is_init(is_init), .cell_val(cell_val),
        .x_coord(x_coord), .y_coord(y_coord), .rev_x(rev_x), .rev_y(rev_y),
        .rev_bit(rev_bit), .busy(busy), .done(done), .hit_mine(hit_mine),
        .revealed_count(revealed_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Layout 0: mines at (4,4),(5,4),(6,6),(2,7). Layout 1: mines fill column 15.
    function automatic int mine_at(input int lay, input int x, input int y);
        if (x < 0 || x > 15 || y < 0 || y > 15) return 0;
        if (lay == 1) return (x == 15) ? 1 : 0;
        return ((x == 4 && y == 4) || (x == 5 && y == 4) ||
                (x == 6 && y == 6) || (x == 2 && y == 7)) ? 1 : 0;
    endfunction

    function automatic logic [4:0] board_cell(input int lay, input int x, input int y);
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dx != 0 || dy != 0) n += mine_at(lay, x + dx, y + dy);
        return {mine_at(lay, x, y) != 0, 4'(n)};
    endfunction

    // Board reads the registered query address; data is sampled at the next edge.
    assign cell_val = board_cell(layout, int'(x_coord), int'(y_coord));

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_op(input int x, input int y, input int budget,
                          output int lat, output logic busy0);
        @(negedge clk);
        sel_x = 4'(x);
        sel_y = 4'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat   = -1;
        for (int j = 0; j < budget; j++) begin
            if (done === 1'b1) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) @(negedge clk);
    endtask

    task automatic peek(input int x, input int y, output logic b);
        rev_x = 4'(x);
        rev_y = 4'(y);
        #1;
        b = rev_bit;
    endtask

    task automatic scan(output int ones, output int bad);
        ones = 0;
        bad  = 0;
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                rev_x = 4'(xx);
                rev_y = 4'(yy);
                #1;
                if (rev_bit === 1'b1) ones++;
                if (rev_bit !== (xx < 15)) bad++;
            end
        end
    endtask

    typedef struct {
        int   sx;
        int   sy;
        int   lat;
        int   cnt;
        logic hit;
        logic rbit;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   lat, ones, bad, dc0;
        logic b0, rb;

        vecs[0] = '{5, 5,  3, 1, 1'b0, 1'b1};
        vecs[1] = '{3, 3,  3, 2, 1'b0, 1'b1};
        vecs[2] = '{5, 5,  1, 2, 1'b0, 1'b1};
        vecs[3] = '{6, 5,  3, 3, 1'b0, 1'b1};
        vecs[4] = '{2, 7,  3, 4, 1'b1, 1'b1};
        vecs[5] = '{9, 9, -1, 4, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; clear = 1'b0; is_init = 1'b0;
        sel_x = '0; sel_y = '0; rev_x = '0; rev_y = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit_mine, 0);
        check("rst_count", revealed_count, 0);
        check("rst_xcoord", x_coord, 0);
        check("rst_ycoord", y_coord, 0);
        check("rst_state", dbg_state, 0);
        scan(ones, bad);
        check("rst_bitmap", ones, 0);

        run_op(5, 5, 8, lat, b0);
        check("noinit_done", lat, -1);
        check("noinit_busy", b0, 0);
        check("noinit_count", revealed_count, 0);

        is_init = 1'b1;
        layout  = 1;
        @(negedge clk);
        sel_x = 4'd0; sel_y = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("midflood_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", revealed_count, 0);
        check("midrst_xcoord", x_coord, 0);
        check("midrst_hit", hit_mine, 0);
        scan(ones, bad);
        check("midrst_bitmap", ones, 0);
        @(negedge clk);
        reset  = 1'b0;
        layout = 0;

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(9'(vecs[i].cnt));
            run_op(vecs[i].sx, vecs[i].sy, 12, lat, b0);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), b0, vecs[i].lat >= 0);
            check($sformatf("v%0d_done_low", i), done, 0);
            check($sformatf("v%0d_count", i), revealed_count, exp_q.pop_front());
            check($sformatf("v%0d_hit", i), hit_mine, vecs[i].hit);
            peek(vecs[i].sx, vecs[i].sy, rb);
            check($sformatf("v%0d_revbit", i), rb, vecs[i].rbit);
            check($sformatf("v%0d_idle", i), busy, 0);
        end

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_hit", hit_mine, 0);
        check("clr_count", revealed_count, 0);
        peek(5, 5, rb);
        check("clr_revbit", rb, 0);

        layout = 1;
        run_op(0, 0, 6000, lat, b0);
        check("flood_done_seen", lat > 3, 1);
        check("flood_count", revealed_count, 240);
        check("flood_hit", hit_mine, 0);
        scan(ones, bad);
        check("flood_ones", ones, 240);
        check("flood_col15_clean", bad, 0);
        peek(15, 0, rb);
        check("flood_rev_15_0", rb, 0);
        peek(14, 15, rb);
        check("flood_rev_14_15", rb, 1);

        run_op(3, 3, 12, lat, b0);
        check("repeat_latency", lat, 1);
        check("repeat_count", revealed_count, 240);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sel_x = 4'd0; sel_y = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 20 && dbg_state != 3'd3; j++) @(negedge clk);
        check("reach_nbr", dbg_state, 3);
        dc0   = done_cnt;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("nbrclr_busy", busy, 0);
        check("nbrclr_count", revealed_count, 0);
        check("nbrclr_hit", hit_mine, 0);
        repeat (10) @(negedge clk);
        check("nbrclr_no_done", done_cnt, dc0);

        sel_x = 4'd5; sel_y = 4'd5; start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("startclr_busy", busy, 0);
        check("startclr_count", revealed_count, 0);
        repeat (6) @(negedge clk);
        check("startclr_no_done", done_cnt, dc0);

        layout = 0;
        run_op(5, 5, 12, lat, b0);
        check("post_clear_latency", lat, 3);
        check("post_clear_count", revealed_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
